shift_register_deserializer: RTL

Serial-in, parallel-out receiver: the other end of the CPU's parallel-in/serial-out enabled shift register. It collects a bit-serial stream, one bit per accepted clock, into WIDTH-bit words and presents each completed word on a valid/ready output port. A separate holding register double-buffers the output, so the next frame can shift in while the previous word waits for the consumer.

---
 rtl/shift_register_deserializer.sv | 92 +++++++++
 1 files changed

// File: rtl/shift_register_deserializer.sv
// Serial-in/parallel-out receiver: one bit per accepted cycle into WIDTH-bit words, double-buffered output.
// dataValid rises one cycle after the last bit; a word completing while the held word is unconsumed is dropped and flags overrun.
module shift_register_deserializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             serialIn,
  input  logic             serialValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  input  logic             dataReady,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] POS0 = MSB_FIRST ? LAST : '0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] sr, sr_nxt, word;
  logic             complete;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
    end
  end

  // word is the shift register with the current bit merged in at its slot
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    complete  = 1'b0;
    pos       = MSB_FIRST ? (LAST - cnt) : cnt;
    word      = sr;
    word[pos] = serialIn;
    if (serialValid) begin
      if (frameStart) begin
        sr_nxt       = '0;
        sr_nxt[POS0] = serialIn;
        cnt_nxt      = CW'(1);
        state_nxt    = SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == LAST) begin
          complete  = 1'b1;
          sr_nxt    = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          sr_nxt  = word;
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  assign busy = (state == SHIFT);

  // A handshake on the completion edge frees the holding register for the new word
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete) begin
      if (!dataValid || dataReady) begin
        dataOut   <= word;
        dataValid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (dataValid && dataReady) begin
      dataValid <= 1'b0;
    end
  end

endmodule
